// File: rtl/aes_pkg.sv
// Shared AES helpers for the decryption core.
//   state_t        : controller states
//   sbox/inv_sbox  : byte substitution, derived from the GF(2^8) inverse plus
//                    the affine map so no 256-entry tables are needed
//   sub_word       : SubWord on a 32-bit key word
//   rcon           : round constant for rounds 1..10 (0 elsewhere)
//   xtime/gf_mul   : GF(2^8) arithmetic, with x9/x11/x13/x14 shorthands
package aes_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEYEXP,
      ST_ADDRK,
      ST_DEC,
      ST_DONE
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xtime(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] b);
      return gf_mul(b, 8'h09);
   endfunction

   function automatic logic [7:0] mul11(input logic [7:0] b);
      return gf_mul(b, 8'h0b);
   endfunction

   function automatic logic [7:0] mul13(input logic [7:0] b);
      return gf_mul(b, 8'h0d);
   endfunction

   function automatic logic [7:0] mul14(input logic [7:0] b);
      return gf_mul(b, 8'h0e);
   endfunction

   // b^254 = b^-1 (and 0 -> 0): product of b^2, b^4 ... b^128.
   function automatic logic [7:0] gf_inv(input logic [7:0] b);
      logic [7:0] r, sq;
      r  = 8'h01;
      sq = b;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] v;
      v = gf_inv(b);
      return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_dec_core_dec_round.sv
// One inverse AES round, purely combinational:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when last=1)
// Ports: state (round input), rk (round key), last (final round, no InvMixColumns),
//        result (round output). Byte n sits at bits [127-8n -: 8], column-major.
module dec_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] rk,
   input  logic         last,
   output logic [127:0] result
);

   logic [127:0] x;
   logic [127:0] y;

   always_comb begin
      logic [7:0] a0, a1, a2, a3;
      x  = '0;
      y  = '0;
      a0 = '0;
      a1 = '0;
      a2 = '0;
      a3 = '0;
      // row r rotates right by r: output column c takes input column c-r
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            x[127-8*(r+4*c) -: 8] = inv_sbox(state[127-8*(r+4*((c-r+4)%4)) -: 8])
                                    ^ rk[127-8*(r+4*c) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         a0 = x[127-32*c -: 8];
         a1 = x[119-32*c -: 8];
         a2 = x[111-32*c -: 8];
         a3 = x[103-32*c -: 8];
         y[127-32*c -: 8] = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
         y[119-32*c -: 8] = mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
         y[111-32*c -: 8] = mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3);
         y[103-32*c -: 8] = mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3);
      end
      result = last ? x : y;
   end

endmodule

// File: rtl/aes_dec_core.sv
// Iterative AES-128 decryption core. Expands the cipher key forward to the
// round-10 key, then runs ten inverse rounds while stepping the key backwards,
// so no round-key storage is kept. One block in flight.
// Ports: clk, rst (sync, active-high), in_valid/in_ready + ciphertext/key in,
//        out_valid/out_ready + plaintext out.
//
// state     | meaning
// ST_IDLE   | waiting for a block, in_ready=1
// ST_KEYEXP | forward key expansion, rnd 1..10
// ST_ADDRK  | whitening with round-10 key
// ST_DEC    | inverse rounds, rnd 9..0
// ST_DONE   | plaintext presented, waiting for out_ready
module aes_dec_core
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ciphertext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plaintext
);

   function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0]  ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Undo key_fwd: recover w3..w1 by XOR, then w0 needs the recovered w3.
   function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w3 = k[31:0]  ^ k[63:32];
      w2 = k[63:32] ^ k[95:64];
      w1 = k[95:64] ^ k[127:96];
      w0 = k[127:96] ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
      return {w0, w1, w2, w3};
   endfunction

   state_t       state_q, state_nxt;
   logic [3:0]   rnd_q;
   logic [127:0] st_q;
   logic [127:0] key_q;
   logic [127:0] pt_q;
   logic [127:0] key_back;
   logic [127:0] round_out;

   assign key_back = key_bwd(key_q, rcon(rnd_q + 4'd1));

   dec_round u_dec_round (
      .state  (st_q),
      .rk     (key_back),
      .last   (rnd_q == 4'd0),
      .result (round_out)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE:   if (in_valid)        state_nxt = ST_KEYEXP;
         ST_KEYEXP: if (rnd_q == 4'd10)  state_nxt = ST_ADDRK;
         ST_ADDRK:                       state_nxt = ST_DEC;
         ST_DEC:    if (rnd_q == 4'd0)   state_nxt = ST_DONE;
         ST_DONE:   if (out_ready)       state_nxt = ST_IDLE;
         default:                        state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rnd_q <= 4'd0;
         st_q  <= '0;
         key_q <= '0;
         pt_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  st_q  <= ciphertext;
                  key_q <= key;
                  rnd_q <= 4'd1;
               end
            end
            ST_KEYEXP: begin
               key_q <= key_fwd(key_q, rcon(rnd_q));
               if (rnd_q != 4'd10) rnd_q <= rnd_q + 4'd1;
            end
            ST_ADDRK: begin
               st_q  <= st_q ^ key_q;
               rnd_q <= 4'd9;
            end
            ST_DEC: begin
               key_q <= key_back;
               if (rnd_q == 4'd0) begin
                  pt_q <= round_out;
               end else begin
                  st_q  <= round_out;
                  rnd_q <= rnd_q - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign plaintext = pt_q;

endmodule

// File: tb/tb_aes_dec_core.sv
module tb_aes_dec_core;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ciphertext;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] plaintext;

   aes_dec_core dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ciphertext (ciphertext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .plaintext  (plaintext)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
      else             n_pass++;
   endtask

   // ---------------- reference AES (byte-level, full key schedule) ----------
   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   function automatic logic [7:0] rl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p = 8'h00; aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   // S-box built by walking the multiplicative group with generator 3.
   task automatic build_tables();
      logic [7:0] p, q, v;
      p = 8'h01; q = 8'h01;
      for (int k = 0; k < 255; k++) begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         v = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
         sb[p] = v ^ 8'h63;
      end
      sb[0] = 8'h63;
      for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
   endtask

   function automatic logic [7:0] gb(input logic [127:0] v, input int i);
      return v[127-8*i -: 8];
   endfunction

   function automatic logic [127:0] rk_of(input logic [127:0] k, input int n);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
   endfunction

   function automatic logic [127:0] sub_b(input logic [127:0] s, input bit inv);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? isb[gb(s, i)] : sb[gb(s, i)];
      return o;
   endfunction

   function automatic logic [127:0] shift_r(input logic [127:0] s, input bit inv);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = gb(s, r + 4*(inv ? (c - r + 4) % 4 : (c + r) % 4));
      return o;
   endfunction

   function automatic logic [127:0] mix_c(input logic [127:0] s, input bit inv);
      logic [7:0]   cf [4];
      logic [7:0]   acc;
      logic [127:0] o;
      if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
      else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gm(cf[(j - r + 4) % 4], gb(s, j + 4*c));
            o[127-8*(r+4*c) -: 8] = acc;
         end
      return o;
   endfunction

   function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
      logic [127:0] s;
      s = pt ^ rk_of(k, 0);
      for (int r = 1; r <= 10; r++) begin
         s = shift_r(sub_b(s, 0), 0);
         if (r < 10) s = mix_c(s, 0);
         s = s ^ rk_of(k, r);
      end
      return s;
   endfunction

   function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [127:0] k);
      logic [127:0] s;
      s = ct ^ rk_of(k, 10);
      for (int r = 9; r >= 0; r--) begin
         s = sub_b(shift_r(s, 1), 1) ^ rk_of(k, r);
         if (r > 0) s = mix_c(s, 1);
      end
      return s;
   endfunction

   // ---------------- transaction-level timing model -------------------------
   bit           m_busy, m_done;
   int           m_cnt;
   logic [127:0] m_exp, m_pt;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 0; m_done <= 0; m_cnt <= 0; m_pt <= '0;
      end else if (m_done) begin
         if (out_ready) m_done <= 0;
      end else if (m_busy) begin
         if (m_cnt == 20) begin
            m_busy <= 0; m_done <= 1; m_pt <= m_exp;
         end
         m_cnt <= m_cnt + 1;
      end else if (in_valid) begin
         m_busy <= 1; m_cnt <= 0;
         m_exp  <= ref_decrypt(ciphertext, key);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready",  {127'd0, in_ready},  {127'd0, !(m_busy || m_done)});
         check("out_valid", {127'd0, out_valid}, {127'd0, m_done});
         check("plaintext", plaintext, m_pt);
      end
   end

   // ---------------- stimulus helpers ---------------------------------------
   // Returns at the falling edge right after the handshake edge.
   task automatic send(input logic [127:0] ct, input logic [127:0] k);
      int w = 0;
      while (!in_ready && w < 100) begin @(negedge clk); w++; end
      if (!in_ready) begin
         $display("FAIL send_timeout got=0 exp=1");
         n_total++;
      end
      in_valid = 1; ciphertext = ct; key = k;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
   endtask

   int lat;
   logic [127:0] rk_, rp_, rc_;

   initial begin
      rst = 1; in_valid = 0; out_ready = 1; ciphertext = '0; key = '0;
      build_tables();
      check("model_c1_dec", ref_decrypt(C1_CT, C1_KEY), C1_PT);
      check("model_b_enc",  ref_encrypt(B_PT, B_KEY), B_CT);
      check("model_b_rk10", rk_of(B_KEY, 10), B_RK10);

      repeat (3) @(negedge clk);
      rst = 0; chk_en = 1;
      check("rst_in_ready",  {127'd0, in_ready},  128'd1);
      check("rst_out_valid", {127'd0, out_valid}, 128'd0);
      check("rst_plaintext", plaintext, 128'h0);

      // C.1 with latency
      send(C1_CT, C1_KEY);
      wait_out(lat);
      check("c1_latency", lat, 21);
      check("c1_pt", plaintext, C1_PT);

      // Appendix B, round-10 key visible while whitening
      send(B_CT, B_KEY);
      repeat (10) @(negedge clk);
      check("b_rk10", dut.key_q, B_RK10);
      wait_out(lat);
      check("b_latency", lat, 11);
      check("b_pt", plaintext, B_PT);

      // back-pressure with a competing request held on the input
      @(negedge clk);
      out_ready = 0;
      send(C1_CT, C1_KEY);
      wait_out(lat);
      check("bp_latency", lat, 21);
      in_valid = 1; ciphertext = B_CT; key = B_KEY;
      repeat (50) begin
         @(negedge clk);
         check("bp_pt", plaintext, C1_PT);
         check("bp_in_ready", {127'd0, in_ready}, 128'd0);
         check("bp_out_valid", {127'd0, out_valid}, 128'd1);
      end
      in_valid = 0; out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      check("bp_release_idle", {127'd0, in_ready}, 128'd1);
      check("bp_release_valid", {127'd0, out_valid}, 128'd0);
      out_ready = 1;

      // inputs wiggle while busy; second block waits for IDLE
      send(B_CT, B_KEY);
      in_valid = 1;
      for (int i = 0; i < 18; i++) begin
         ciphertext = {$urandom, $urandom, $urandom, $urandom};
         key        = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
      end
      ciphertext = C1_CT; key = C1_KEY;
      wait_out(lat);
      check("stab_first_pt", plaintext, B_PT);
      send(C1_CT, C1_KEY);
      wait_out(lat);
      check("stab_second_latency", lat, 21);
      check("stab_second_pt", plaintext, C1_PT);

      // reset while DEC is at rnd=5
      @(negedge clk);
      send(B_CT, B_KEY);
      repeat (15) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
      check("mid_rst_plaintext", plaintext, 128'h0);
      check("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
      send(C1_CT, C1_KEY);
      wait_out(lat);
      check("post_rst_latency", lat, 21);
      check("post_rst_pt", plaintext, C1_PT);

      // random round trip
      for (int i = 0; i < 200; i++) begin
         rk_ = {$urandom, $urandom, $urandom, $urandom};
         rp_ = {$urandom, $urandom, $urandom, $urandom};
         rc_ = ref_encrypt(rp_, rk_);
         @(negedge clk);
         send(rc_, rk_);
         wait_out(lat);
         check("rt_latency", lat, 21);
         check("rt_pt", plaintext, rp_);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/aes_dec_core.md
# aes_dec_core

Iterative AES-128 decryption core: the inverse-cipher counterpart of the encryption round datapath. It accepts a 128-bit ciphertext and the 128-bit cipher key over a valid/ready handshake. It then expands the key forward to the round-10 key and runs ten inverse rounds, regenerating round keys backwards on the fly. The plaintext is returned over a valid/ready handshake. One block is in flight at a time, and no round-key storage is needed.

## Interface
- No parameters (AES-128 only; Nr = 10 fixed).
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ciphertext/key present
- in_ready  out  1  core can accept (high only in IDLE)
- ciphertext  in  128  byte 0 = bits [127:120], FIPS-197 column-major
- key  in  128  cipher key (round-0 key), same byte order
- out_valid  out  1  plaintext valid
- out_ready  in  1  consumer accepts plaintext
- plaintext  out  128  decrypted block, same byte order

## Operation
- FSM states: IDLE, KEYEXP, ADDRK, DEC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture ciphertext into the state register and key into the key register.
  - Set rnd=1 and go to KEYEXP.
- KEYEXP: each cycle, key ← next forward round key using Rcon[rnd]. When rnd=10, go to ADDRK; else rnd++.
- ADDRK: state ← state ^ key (rk10); set rnd=9; go to DEC.
- DEC, per cycle:
  - Step the key backwards: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^Rcon[rnd+1].
  - Let x = InvSubBytes(InvShiftRows(state)) ^ key'.
  - rnd≥1: state ← InvMixColumns(x).
  - rnd=0: plaintext ← x and go to DONE. Otherwise rnd--.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (byte placed in bits [31:24] of the word).
- DONE:
  - out_valid=1 and plaintext held stable.
  - On out_ready, go to IDLE; out_valid drops next cycle. Plaintext keeps its last value.
- Inputs changing after capture have no effect. in_valid in any non-IDLE state is ignored (in_ready=0).
- Reset (any state, including mid-round):
  - FSM→IDLE, rnd=0, out_valid=0, plaintext=0.
  - State and key registers are cleared to 0. The in-flight block is discarded.
- Reset values: in_ready=1 after the reset cycle, out_valid=0, plaintext=128'h0.

## Timing
- Handshake captured at edge T.
- KEYEXP occupies edges T+1..T+10; ADDRK is edge T+11; DEC occupies edges T+12..T+21.
- out_valid is registered high from edge T+21: fixed 21-cycle latency, no data dependence.
- If out_ready is already high, DONE lasts exactly 1 cycle. IDLE follows, so the next handshake can occur at edge T+23.
- Minimum initiation interval: 23 cycles.
- Back-pressure: DONE persists indefinitely with out_valid and plaintext stable.
- All outputs are registered or decoded from FSM state only. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `aes_pkg`:
  - forward S-box and inverse S-box functions;
  - Rcon table;
  - xtime/gf-multiply helpers (×9, ×11, ×13, ×14);
  - FSM state enum.
- Sub-module `dec_round`: combinational InvShiftRows → InvSubBytes → AddRoundKey, then InvMixColumns bypassed by a `last` input. It mirrors the encryption round and its no-MixColumns variant in one module.
- Key stepping (forward and backward) lives in the top as two small functions using the package S-box.

## Test plan
- FIPS-197 C.1:
  - ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102030405060708090a0b0c0d0e0f.
  - Required: plaintext 00112233445566778899aabbccddeeff, out_valid exactly 21 cycles after the handshake.
- FIPS-197 Appendix B:
  - ciphertext 3925841d02dc09fbdc118597196a0b32, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: plaintext 3243f6a8885a308d313198a2e0370734.
  - Internal key register equals d014f9a8c9ee2589e13f0cc8b6630ca6 in ADDRK.
- Back-pressure: hold out_ready=0 for 50 cycles after out_valid.
  - Required: plaintext stable, in_ready=0, no extra accepts.
  - Then pulse out_ready: IDLE next cycle.
- Input stability: change ciphertext/key and hold in_valid=1 during KEYEXP/DEC.
  - Required: first result unaffected.
  - The second block is accepted only in IDLE and decrypts correctly.
- Reset mid-DEC (rnd=5): assert rst for 1 cycle.
  - Required: out_valid=0, plaintext=0, in_ready=1 next cycle.
  - A fresh C.1 vector then decrypts correctly.
- Round trip: 200 random key/plaintext pairs encrypted by the reference model and fed in.
  - Required: every plaintext matches; latency is 21 each time.
